// File: rtl/cb_pkg.sv
// Shared definitions for the parametrised X-channel connection block:
// select-field sizing, the OFF code and the chain-counter states.
package cb_pkg;

    localparam int DEF_CHAN_WIDTH = 5;

    // Select field must hold 2*chan_width track codes plus one OFF code.
    function automatic int sel_bits(input int chan_width);
        return $clog2(2 * chan_width + 1);
    endfunction

    localparam int DEF_SEL_BITS = sel_bits(DEF_CHAN_WIDTH);

    // OFF is the all-ones code; any code >= 2*CHAN_WIDTH also decodes to 0.
    localparam logic [DEF_SEL_BITS-1:0] SEL_OFF = '1;

    typedef enum logic [1:0] {
        CNT_EMPTY,
        CNT_LOADING,
        CNT_FULL,
        CNT_OVER
    } cnt_state_e;

endpackage

// File: rtl/cb_track_mux.sv
// One grid-pin selector: picks a left or right channel track by code,
// or drives constant 0 for OFF and any unused code.
module cb_track_mux
    import cb_pkg::*;
#(
    parameter int CHAN_WIDTH = 5,
    parameter int SEL_BITS   = sel_bits(CHAN_WIDTH)
) (
    input  logic [CHAN_WIDTH-1:0] chan_left,
    input  logic [CHAN_WIDTH-1:0] chan_right,
    input  logic [SEL_BITS-1:0]   sel,
    output logic                  pin_out
);

    logic [2*CHAN_WIDTH-1:0] tracks;

    // Codes 0..CW-1 hit the left tracks, CW..2CW-1 the right tracks.
    assign tracks = {chan_right, chan_left};

    always_comb begin
        pin_out = 1'b0;
        for (int i = 0; i < 2 * CHAN_WIDTH; i++) begin
            if (sel == SEL_BITS'(i)) pin_out = tracks[i];
        end
    end

endmodule

// File: rtl/cbx_param_shadow.sv
// X-channel connection block with a shadow configuration chain that is
// length-checked and applied atomically on cfg_commit.
module cbx_param_shadow
    import cb_pkg::*;
#(
    parameter int CHAN_WIDTH = 5,
    parameter int NUM_IPIN   = 5,
    parameter int SEL_BITS   = sel_bits(CHAN_WIDTH),
    parameter int CHAIN_LEN  = NUM_IPIN * SEL_BITS
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  ccff_en,
    input  logic                  ccff_head,
    input  logic                  cfg_commit,
    output logic                  ccff_tail,
    output logic                  cfg_done,
    output logic                  cfg_err,
    input  logic [CHAN_WIDTH-1:0] chanx_left_in,
    input  logic [CHAN_WIDTH-1:0] chanx_right_in,
    output logic [CHAN_WIDTH-1:0] chanx_left_out,
    output logic [CHAN_WIDTH-1:0] chanx_right_out,
    output logic [NUM_IPIN-1:0]   ipin_out
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_FULL_V = CNT_W'(CHAIN_LEN);

    logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
    logic [CHAIN_LEN-1:0] active_q, active_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_base;
    logic                 ovf_q, ovf_d, ovf_base;
    logic                 err_q, err_d;
    logic                 commit_ok;
    cnt_state_e           cnt_state;

    assign chanx_left_out  = chanx_right_in;
    assign chanx_right_out = chanx_left_in;
    assign ccff_tail       = shadow_q[CHAIN_LEN-1];
    assign cfg_err         = err_q;

    always_comb begin
        if (ovf_q)                   cnt_state = CNT_OVER;
        else if (cnt_q == '0)        cnt_state = CNT_EMPTY;
        else if (cnt_q == CNT_FULL_V) cnt_state = CNT_FULL;
        else                         cnt_state = CNT_LOADING;
    end

    assign cfg_done  = (cnt_state == CNT_FULL);
    assign commit_ok = cfg_commit & cfg_done;

    // A commit decides on and copies the pre-shift chain; a shift in the
    // same cycle then counts from the cleared value.
    always_comb begin
        shadow_d = shadow_q;
        if (ccff_en) shadow_d = {shadow_q[CHAIN_LEN-2:0], ccff_head};

        active_d = commit_ok ? shadow_q : active_q;

        err_d = err_q;
        if (cfg_commit) err_d = ~cfg_done;

        cnt_base = cfg_commit ? '0 : cnt_q;
        ovf_base = cfg_commit ? 1'b0 : ovf_q;
        cnt_d    = cnt_base;
        ovf_d    = ovf_base;
        if (ccff_en) begin
            if (cnt_base == CNT_FULL_V) ovf_d = 1'b1;
            else                        cnt_d = cnt_base + 1'b1;
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            shadow_q <= '0;
            active_q <= '1;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    for (genvar k = 0; k < NUM_IPIN; k++) begin : g_pin
        cb_track_mux #(
            .CHAN_WIDTH(CHAN_WIDTH),
            .SEL_BITS  (SEL_BITS)
        ) u_mux (
            .chan_left (chanx_left_in),
            .chan_right(chanx_right_in),
            .sel       (active_q[k*SEL_BITS +: SEL_BITS]),
            .pin_out   (ipin_out[k])
        );
    end

endmodule

// File: tb/tb_cbx_param_shadow.sv
// Directed bench for cbx_param_shadow: stimulus pushes expected values,
// a monitor pops and compares them against the live outputs.
module tb_cbx_param_shadow;

    logic       prog_clk = 1'b0;
    logic       pReset = 1'b1;
    logic       ccff_en = 1'b0;
    logic       ccff_head = 1'b0;
    logic       cfg_commit = 1'b0;
    logic       ccff_tail, cfg_done, cfg_err;
    logic [4:0] chanx_left_in = '0;
    logic [4:0] chanx_right_in = '0;
    logic [4:0] chanx_left_out, chanx_right_out, ipin_out;

    cbx_param_shadow dut (
        .prog_clk       (prog_clk),
        .pReset         (pReset),
        .ccff_en        (ccff_en),
        .ccff_head      (ccff_head),
        .cfg_commit     (cfg_commit),
        .ccff_tail      (ccff_tail),
        .cfg_done       (cfg_done),
        .cfg_err        (cfg_err),
        .chanx_left_in  (chanx_left_in),
        .chanx_right_in (chanx_right_in),
        .chanx_left_out (chanx_left_out),
        .chanx_right_out(chanx_right_out),
        .ipin_out       (ipin_out)
    );

    always #5 prog_clk = ~prog_clk;

    // Field select for each expectation: 0 ipin, 1 tail, 2 done, 3 err, 4 lo, 5 ro
    typedef struct {
        string      name;
        logic [5:0] care;
        logic [4:0] ipin;
        logic       tail;
        logic       done;
        logic       err;
        logic [4:0] lo;
        logic [4:0] ro;
    } exp_t;

    exp_t sb_q[$];
    event chk_ev;
    int   checks = 0;
    int   failures = 0;

    // Pins 4..0 = sel {15,10,9,6,0}; pin4 field is shifted in first.
    localparam logic [19:0] CFG_A = 20'hFA960;
    // Pins 4..0 = sel {9,4,14,1,5}.
    localparam logic [19:0] CFG_B = 20'h94E15;
    localparam logic [20:0] SEQ21 = {1'b1, 1'b0, 19'h2B3C5};

    task automatic push(input exp_t e);
        sb_q.push_back(e);
        -> chk_ev;
        #1;
    endtask

    task automatic chk_ipin(input string n, input logic [4:0] v);
        exp_t e;
        e = '{name: n, care: 6'b000001, ipin: v, tail: 1'b0, done: 1'b0, err: 1'b0, lo: '0, ro: '0};
        push(e);
    endtask

    task automatic chk_flags(input string n, input logic d, input logic er);
        exp_t e;
        e = '{name: n, care: 6'b001100, ipin: '0, tail: 1'b0, done: d, err: er, lo: '0, ro: '0};
        push(e);
    endtask

    task automatic chk_tail(input string n, input logic t);
        exp_t e;
        e = '{name: n, care: 6'b000010, ipin: '0, tail: t, done: 1'b0, err: 1'b0, lo: '0, ro: '0};
        push(e);
    endtask

    task automatic chk_pass(input string n, input logic [4:0] lo, input logic [4:0] ro);
        exp_t e;
        e = '{name: n, care: 6'b110000, ipin: '0, tail: 1'b0, done: 1'b0, err: 1'b0, lo: lo, ro: ro};
        push(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(chk_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.care[0]) begin
                    checks++;
                    if (ipin_out !== e.ipin) begin
                        failures++;
                        $display("FAIL %s ipin_out got=%b exp=%b", e.name, ipin_out, e.ipin);
                    end
                end
                if (e.care[1]) begin
                    checks++;
                    if (ccff_tail !== e.tail) begin
                        failures++;
                        $display("FAIL %s ccff_tail got=%b exp=%b", e.name, ccff_tail, e.tail);
                    end
                end
                if (e.care[2]) begin
                    checks++;
                    if (cfg_done !== e.done) begin
                        failures++;
                        $display("FAIL %s cfg_done got=%b exp=%b", e.name, cfg_done, e.done);
                    end
                end
                if (e.care[3]) begin
                    checks++;
                    if (cfg_err !== e.err) begin
                        failures++;
                        $display("FAIL %s cfg_err got=%b exp=%b", e.name, cfg_err, e.err);
                    end
                end
                if (e.care[4]) begin
                    checks++;
                    if (chanx_left_out !== e.lo) begin
                        failures++;
                        $display("FAIL %s chanx_left_out got=%h exp=%h", e.name, chanx_left_out, e.lo);
                    end
                end
                if (e.care[5]) begin
                    checks++;
                    if (chanx_right_out !== e.ro) begin
                        failures++;
                        $display("FAIL %s chanx_right_out got=%h exp=%h", e.name, chanx_right_out, e.ro);
                    end
                end
            end
        end
    end

    task automatic shift_bit(input logic b, input logic commit);
        ccff_en    = 1'b1;
        ccff_head  = b;
        cfg_commit = commit;
        @(posedge prog_clk);
        #1;
        ccff_en    = 1'b0;
        cfg_commit = 1'b0;
    endtask

    // Shifts w[hi] first down to w[lo].
    task automatic shift_range(input logic [20:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) shift_bit(w[i], 1'b0);
    endtask

    task automatic do_commit();
        cfg_commit = 1'b1;
        @(posedge prog_clk);
        #1;
        cfg_commit = 1'b0;
    endtask

    task automatic set_ch(input logic [4:0] l, input logic [4:0] r);
        chanx_left_in  = l;
        chanx_right_in = r;
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        repeat (2) @(posedge prog_clk);
        #3;
        pReset = 1'b0;
        @(posedge prog_clk);
        #1;

        // Reset state with all tracks high: everything OFF
        set_ch(5'h1F, 5'h1F);
        chk_ipin("rst_ipin", 5'b00000);
        chk_tail("rst_tail", 1'b0);
        chk_flags("rst_flags", 1'b0, 1'b0);
        chk_pass("pass_1f", 5'h1F, 5'h1F);
        set_ch(5'h0A, 5'h15);
        chk_pass("pass_swap", 5'h15, 5'h0A);

        // Good load of CFG_A
        shift_range({1'b0, CFG_A}, 19, 0);
        chk_flags("a_full", 1'b1, 1'b0);
        chk_tail("a_tail", 1'b1);
        set_ch(5'b00001, 5'b10010);
        chk_ipin("a_precommit", 5'b00000);
        do_commit();
        // sel0->left[0]=1, sel6->right[1]=1, sel9->right[4]=1, 10 and 15 OFF
        chk_ipin("a_route", 5'b00111);
        chk_flags("a_after", 1'b0, 1'b0);

        // Short load (19 bits) is rejected
        shift_range({1'b0, CFG_B}, 19, 1);
        chk_flags("short_load", 1'b0, 1'b0);
        do_commit();
        chk_flags("short_reject", 1'b0, 1'b1);
        chk_ipin("short_hold", 5'b00111);

        // Full load of CFG_B clears the error on commit
        shift_range({1'b0, CFG_B}, 19, 0);
        chk_flags("b_full_err", 1'b1, 1'b1);
        do_commit();
        chk_flags("b_err_clr", 1'b0, 1'b0);
        set_ch(5'b10010, 5'b10001);
        chk_ipin("b_route", 5'b11011);

        // Over-long load: 21 shifts
        shift_range(SEQ21, 20, 1);
        chk_flags("ovr_20", 1'b1, 1'b0);
        chk_tail("ovr_tail20", SEQ21[20]);
        shift_bit(SEQ21[0], 1'b0);
        chk_flags("ovr_21", 1'b0, 1'b0);
        chk_tail("ovr_tail21", SEQ21[19]);
        do_commit();
        chk_flags("ovr_reject", 1'b0, 1'b1);
        chk_ipin("ovr_hold", 5'b11011);

        // Commit together with a shift while FULL
        shift_range({1'b0, CFG_A}, 19, 0);
        chk_flags("cs_full", 1'b1, 1'b1);
        shift_bit(CFG_B[19], 1'b1);
        chk_flags("cs_after", 1'b0, 1'b0);
        set_ch(5'b00001, 5'b10010);
        chk_ipin("cs_route", 5'b00111);
        shift_range({1'b0, CFG_B}, 18, 1);
        chk_flags("cs_cnt19", 1'b0, 1'b0);
        shift_bit(CFG_B[0], 1'b0);
        chk_flags("cs_cnt20", 1'b1, 1'b0);
        do_commit();
        set_ch(5'b10010, 5'b10001);
        chk_ipin("cs_b_route", 5'b11011);

        // Asynchronous reset in the middle of a load
        shift_range({1'b0, CFG_A}, 19, 10);
        pReset = 1'b1;
        #2;
        chk_ipin("arst_ipin", 5'b00000);
        chk_tail("arst_tail", 1'b0);
        chk_flags("arst_flags", 1'b0, 1'b0);
        pReset = 1'b0;
        shift_range({1'b0, CFG_A}, 19, 1);
        chk_flags("arst_cnt19", 1'b0, 1'b0);
        shift_bit(CFG_A[0], 1'b0);
        chk_flags("arst_cnt20", 1'b1, 1'b0);
        do_commit();
        set_ch(5'b00001, 5'b10010);
        chk_ipin("arst_route", 5'b00111);

        #2;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
